// File: rtl/perceptron_weight_updater.sv
// Perceptron predictor training unit: decides whether to train on a resolved branch and
// streams saturated weight updates LANES per cycle. Optional counters under PERC_UPD_STATS_EN.
module perceptron_weight_updater #(
    parameter int HISTORY_LENGTH = 32,
    parameter int WEIGHT_WIDTH   = 8,
    parameter int THETA          = 75,
    parameter int LANES          = 8
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        upd_valid,
    output logic                                        upd_ready,
    input  logic [HISTORY_LENGTH-1:0]                   upd_history,
    input  logic [(HISTORY_LENGTH+1)*WEIGHT_WIDTH-1:0]  upd_weights,
    input  logic [15:0]                                 upd_dot_product,
    input  logic                                        upd_taken,
    output logic                                        wr_valid,
    input  logic                                        wr_ready,
    output logic [(HISTORY_LENGTH+1)*WEIGHT_WIDTH-1:0]  wr_weights,
    output logic                                        wr_trained,
`ifdef PERC_UPD_STATS_EN
    output logic [31:0]                                 stat_trained,
    output logic [31:0]                                 stat_skipped,
`endif
    output logic [1:0]                                  dbg_state
);

    localparam int WW = WEIGHT_WIDTH;
    localparam int HL = HISTORY_LENGTH;
    localparam int VW = (HL + 1) * WW;
    localparam int IW = $clog2(HL + 1);
    localparam logic signed [WW:0] W_MAX = (WW + 1)'((2 ** (WW - 1)) - 1);
    localparam logic signed [WW:0] W_ONE = (WW + 1)'(1);
    localparam logic [IW-1:0] LAST_IDX = IW'(HL - LANES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [HL-1:0]     r_hist;
    logic [VW-1:0]     r_weights;
    logic [15:0]       r_y;
    logic              r_taken;
    logic [IW-1:0]     r_idx;
    logic              r_trained;
    logic [16:0]       w_y_ext;
    logic [16:0]       w_abs_y;
    logic              w_pred;
    logic              w_train;
    logic              w_last;

    // Both handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // upd_ready is high only in IDLE, wr_valid only in DONE, and DONE data is held until wr_ready.
    assign upd_ready  = (r_state == IDLE);
    assign wr_valid   = (r_state == DONE);
    assign wr_weights = r_weights;
    assign wr_trained = r_trained;
    assign dbg_state  = r_state;

    // Magnitude is taken one bit wider so that -32768 becomes +32768 instead of wrapping.
    assign w_y_ext = {r_y[15], r_y};
    assign w_abs_y = r_y[15] ? (17'd0 - w_y_ext) : w_y_ext;
    assign w_pred  = ~r_y[15];
    assign w_train = (w_pred != r_taken) || (w_abs_y <= 17'(THETA));
    assign w_last  = (r_idx == LAST_IDX);

    function automatic logic [WW-1:0] sat_step(input logic [WW-1:0] w, input logic inc);
        logic signed [WW:0] s;
        s = $signed({w[WW-1], w}) + (inc ? W_ONE : -W_ONE);
        if (s > W_MAX) begin
            s = W_MAX;
        end else if (s < -W_MAX) begin
            s = -W_MAX;
        end
        return s[WW-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (upd_valid) w_state_next = EVAL;
            EVAL:    w_state_next = w_train ? UPDATE : DONE;
            UPDATE:  if (w_last) w_state_next = DONE;
            DONE:    if (wr_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist    <= '0;
            r_weights <= '0;
            r_y       <= '0;
            r_taken   <= 1'b0;
            r_idx     <= '0;
            r_trained <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (upd_valid) begin
                        r_hist    <= upd_history;
                        r_weights <= upd_weights;
                        r_y       <= upd_dot_product;
                        r_taken   <= upd_taken;
                        r_idx     <= '0;
                        r_trained <= 1'b0;
                    end
                end
                EVAL: begin
                    r_idx <= '0;
                    if (w_train) begin
                        r_weights[HL*WW +: WW] <= sat_step(r_weights[HL*WW +: WW], r_taken);
                    end
                end
                UPDATE: begin
                    for (int i = 0; i < HL; i++) begin
                        if ((i >= int'(r_idx)) && (i < int'(r_idx) + LANES)) begin
                            r_weights[i*WW +: WW] <= sat_step(r_weights[i*WW +: WW],
                                                              r_hist[i] == r_taken);
                        end
                    end
                    r_idx <= r_idx + IW'(LANES);
                    if (w_last) begin
                        r_trained <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PERC_UPD_STATS_EN
    logic [31:0] r_stat_trained;
    logic [31:0] r_stat_skipped;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_trained <= '0;
            r_stat_skipped <= '0;
        end else if ((r_state == DONE) && wr_ready) begin
            if (r_trained) begin
                if (r_stat_trained != 32'hFFFF_FFFF) r_stat_trained <= r_stat_trained + 32'd1;
            end else begin
                if (r_stat_skipped != 32'hFFFF_FFFF) r_stat_skipped <= r_stat_skipped + 32'd1;
            end
        end
    end

    assign stat_trained = r_stat_trained;
    assign stat_skipped = r_stat_skipped;
`endif

endmodule

// File: tb/tb_perceptron_weight_updater.sv
// Scoreboard bench for perceptron_weight_updater: directed vectors with hand-computed results,
// a monitor pops expected {trained, weights} on each write-back handshake.
module tb_perceptron_weight_updater;

    localparam int HL = 32;
    localparam int WW = 8;
    localparam int NW = HL + 1;
    localparam int VW = NW * WW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              upd_valid = 1'b0;
    logic              upd_ready;
    logic [HL-1:0]     upd_history = '0;
    logic [VW-1:0]     upd_weights = '0;
    logic [15:0]       upd_dot_product = '0;
    logic              upd_taken = 1'b0;
    logic              wr_valid;
    logic              wr_ready = 1'b1;
    logic [VW-1:0]     wr_weights;
    logic              wr_trained;
    logic [1:0]        dbg_state;
`ifdef PERC_UPD_STATS_EN
    logic [31:0]       stat_trained;
    logic [31:0]       stat_skipped;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [VW:0] exp_q[$];

    perceptron_weight_updater dut (
        .clk             (clk),
        .rst             (rst),
        .upd_valid       (upd_valid),
        .upd_ready       (upd_ready),
        .upd_history     (upd_history),
        .upd_weights     (upd_weights),
        .upd_dot_product (upd_dot_product),
        .upd_taken       (upd_taken),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_weights      (wr_weights),
        .wr_trained      (wr_trained),
`ifdef PERC_UPD_STATS_EN
        .stat_trained    (stat_trained),
        .stat_skipped    (stat_skipped),
`endif
        .dbg_state       (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [VW:0] got, input logic [VW:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic logic [VW-1:0] fill(input logic [WW-1:0] v);
        logic [VW-1:0] r;
        for (int i = 0; i < NW; i++) r[i*WW +: WW] = v;
        return r;
    endfunction

    // Monitor: pop and compare on every write-back handshake
    always @(negedge clk) begin
        if (!rst && wr_valid && wr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write got=%h want=none", {wr_trained, wr_weights});
            end else begin
                chk("writeback", {wr_trained, wr_weights}, exp_q.pop_front());
            end
        end
    end

    // Drive a request and wait for its acceptance edge
    task automatic start_req(input logic [HL-1:0] h, input logic [VW-1:0] w,
                             input logic [15:0] y, input logic t);
        int n;
        @(negedge clk);
        upd_history = h;
        upd_weights = w;
        upd_dot_product = y;
        upd_taken = t;
        upd_valid = 1'b1;
        n = 0;
        while (!upd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!upd_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout got=%0d want=ready", n);
        end
        @(posedge clk);
        #1 upd_valid = 1'b0;
    endtask

    task automatic send(input string name, input logic [HL-1:0] h, input logic [VW-1:0] w,
                        input logic [15:0] y, input logic t,
                        input logic exp_tr, input logic [VW-1:0] exp_w, input int exp_lat);
        int lat;
        exp_q.push_back({exp_tr, exp_w});
        start_req(h, w, y, t);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!wr_valid && lat < 40);
        chk({name, "_latency"}, (VW+1)'(lat), (VW+1)'(exp_lat));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", (VW+1)'(exp_q.size()), '0);
    endtask

    initial begin
        logic [VW-1:0] w;
        logic [VW-1:0] e;

        // Reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_upd_ready", (VW+1)'(upd_ready), 1);
        chk("rst_wr_valid", (VW+1)'(wr_valid), 0);
        chk("rst_wr_trained", (VW+1)'(wr_trained), 0);
        chk("rst_wr_weights", (VW+1)'(wr_weights), 0);
        chk("rst_state", (VW+1)'(dbg_state), 0);
`ifdef PERC_UPD_STATS_EN
        chk("rst_stats", (VW+1)'({stat_trained, stat_skipped}), 0);
`endif

        // 1: mispredict at y=0
        e = fill(8'h01);
        for (int i = 0; i < 16; i++) e[i*WW +: WW] = 8'hFF;
        e[HL*WW +: WW] = 8'hFF;
        send("mispredict", 32'h0000_FFFF, '0, 16'd0, 1'b0, 1'b1, e, 6);

        // 2: confident correct, weights pass through unchanged
        for (int i = 0; i < NW; i++) w[i*WW +: WW] = 8'(i * 3 - 40);
        send("confident", 32'hA5A5_3C3C, w, 16'd100, 1'b1, 1'b0, w, 2);

        // 3: threshold edges
        send("y75", '1, '0, 16'd75, 1'b1, 1'b1, fill(8'h01), 6);
        send("y76", '1, '0, 16'd76, 1'b1, 1'b0, '0, 2);
        send("y_min", '1, fill(8'h05), 16'h8000, 1'b0, 1'b0, fill(8'h05), 2);
        send("y_neg75", '1, '0, -16'sd75, 1'b0, 1'b1, fill(8'hFF), 6);

        // 4: saturation at both ends
        send("sat_hi", '1, fill(8'h7F), -16'sd5, 1'b1, 1'b1, fill(8'h7F), 6);
        send("sat_lo", '1, fill(8'h81), 16'd10, 1'b0, 1'b1, fill(8'h81), 6);
        send("sat_m128", 32'h0000_FFFF, fill(8'h80), 16'd5, 1'b1, 1'b1, fill(8'h81), 6);
        drain();

        // 5: backpressure in DONE; a competing request must be ignored
        #1 wr_ready = 1'b0;
        w = fill(8'h33);
        send("bp", 32'h1234_5678, w, 16'd200, 1'b1, 1'b0, w, 2);
        upd_valid = 1'b1;
        upd_weights = fill(8'h11);
        upd_dot_product = 16'd0;
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid", (VW+1)'(wr_valid), 1);
            chk("bp_weights", (VW+1)'(wr_weights), (VW+1)'(w));
            chk("bp_upd_ready", (VW+1)'(upd_ready), 0);
            @(negedge clk);
        end
        upd_valid = 1'b0;
        @(posedge clk);
        #1 wr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_idle", (VW+1)'({wr_valid, upd_ready}), 2'b01);
        repeat (8) @(negedge clk);
        chk("bp_no_extra", (VW+1)'(wr_valid), 0);
        drain();

        // 6: reset during UPDATE abandons the request
        start_req('1, fill(8'h10), 16'd3, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid_state_update", (VW+1)'(dbg_state), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", (VW+1)'(wr_valid), 0);
        @(negedge clk);
        chk("mid_rst_ready", (VW+1)'(upd_ready), 1);
        chk("mid_rst_weights", (VW+1)'(wr_weights), 0);
`ifdef PERC_UPD_STATS_EN
        chk("mid_rst_stats", (VW+1)'({stat_trained, stat_skipped}), 0);
`endif
        repeat (8) @(negedge clk);
        chk("mid_rst_no_write", (VW+1)'(wr_valid), 0);

        // Back to normal after reset; with stats, one trained and one skipped
        e = fill(8'h01);
        for (int i = 0; i < 16; i++) e[i*WW +: WW] = 8'hFF;
        e[HL*WW +: WW] = 8'hFF;
        send("post_rst_train", 32'h0000_FFFF, '0, 16'd0, 1'b0, 1'b1, e, 6);
        w = fill(8'hC4);
        send("post_rst_skip", 32'hFFFF_0000, w, 16'd100, 1'b1, 1'b0, w, 2);
        drain();
        @(negedge clk);
`ifdef PERC_UPD_STATS_EN
        chk("stat_trained", (VW+1)'(stat_trained), 1);
        chk("stat_skipped", (VW+1)'(stat_skipped), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d want=done", cyc);
        $fatal(1);
    end

endmodule
